sample_window: RTL
==================

SAMPLE_WINDOW -- requirements
Module: sample_window

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning sample buffer entries (power of 2, >= WIN).
REQ-002 SHALL have parameter WIN, default 8, meaning samples per statistics window (>= 1).
REQ-003 SHALL have parameter STRIDE, default 4, meaning new samples between successive windows (>= 1).
REQ-004 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  upstream sample valid.
REQ-007 SHALL have port in_data  input  32  upstream sample value, unsigned.
REQ-008 SHALL have port in_ready  output  1  block can accept a sample.
REQ-009 SHALL have port stat_start  output  1  one-cycle start pulse to the statistics engine.
REQ-010 SHALL have port stat_si  output  32  window start index, inclusive.
REQ-011 SHALL have port stat_ei  output  32  window end index, exclusive.
REQ-012 SHALL have port stat_index  input  32  read index driven by the statistics engine.
REQ-013 SHALL have port stat_value  output  32  sample at stat_index.
REQ-014 SHALL have port stat_done  input  1  engine finished; results valid this cycle.
REQ-015 SHALL have ports stat_mean and stat_variance  input  32 each  engine results.
REQ-016 SHALL have ports res_valid (output 1) and res_si, res_mean, res_variance (output 32 each)  captured window result.

Function
REQ-017 SHALL accept a sample only on a cycle with in_valid && in_ready; it is written to mem[wr_cnt mod DEPTH], then wr_cnt increments (32-bit, wraps at 2^32).
REQ-018 SHALL drive stat_value combinationally as mem[stat_index mod DEPTH], with no latency; a write and a read of the same entry in one cycle returns the old data.
REQ-019 SHALL implement states FILL, RUN, ISSUE, WAIT; FILL and RUN have in_ready=1, ISSUE and WAIT have in_ready=0.
REQ-020 FILL -> ISSUE on the acceptance that makes total accepted == WIN; stride_cnt cleared.
REQ-021 RUN -> ISSUE on an acceptance where stride_cnt+1 == STRIDE (stride_cnt cleared), else stride_cnt increments.
REQ-022 On entering ISSUE, SHALL set stat_ei = wr_cnt after the increment and stat_si = stat_ei - WIN (mod 2^32); both held stable until the next ISSUE.
REQ-023 ISSUE SHALL last exactly one cycle with stat_start=1, then go to WAIT; stat_start is 0 in every other state.
REQ-024 WAIT -> RUN on stat_done=1, capturing res_mean, res_variance and res_si=stat_si; res_valid=1 for exactly the following cycle.
REQ-025 SHALL ignore stat_done in FILL, RUN and ISSUE.
REQ-026 SHALL keep in_ready=0 in WAIT indefinitely if stat_done never arrives; there is no timeout.

Reset
REQ-027 Rst=1 SHALL immediately force: state FILL, wr_cnt 0, stride_cnt 0, stat_start 0, stat_si 0, stat_ei 0, res_valid 0, res_si/res_mean/res_variance 0; in_ready=1 after release.
REQ-028 Buffer memory is not reset; reset mid-WAIT abandons the window with no res_valid.

Structure
REQ-029 SHALL place DATA_W=32 and the state encoding in shared package stats_pkg.
REQ-030 SHALL instantiate one sub-module sample_ram (DEPTH x DATA_W, synchronous write, asynchronous read).

Verification (WIN=8, STRIDE=4, DEPTH=16)
REQ-031 Feed 10,20,...,80 -> stat_start one cycle after the 8th acceptance; si=0, ei=8; stat_index=3 gives stat_value=40.
REQ-032 Pulse stat_done with mean=45 and var=20, then feed 4 more samples -> res_valid once with res_si=0, res_mean=45; second start with si=4, ei=12.
REQ-033 Hold in_valid=1 throughout WAIT -> in_ready=0 and wr_cnt is unchanged until stat_done arrives.
REQ-034 Feed 20 samples of value i+1 (i=0..19) -> stat_index=17 gives 18, and stat_index=1 gives 18 (aliasing).
REQ-035 Pulse stat_done in RUN -> no res_valid; Rst asserted in WAIT -> all outputs 0, FILL, and 8 new samples are needed before the next start.

Source files
------------

// File: rtl/stats_pkg.sv
// Shared definitions for the sample window block: data width and FSM encoding.
package stats_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,   // collecting the first WIN samples
        ST_RUN   = 2'd1,   // collecting STRIDE samples for the next window
        ST_ISSUE = 2'd2,   // one-cycle start pulse to the statistics engine
        ST_WAIT  = 2'd3    // engine busy, input stalled
    } state_t;

    // Address width for a power-of-two buffer, never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// Sample buffer: one synchronous write port, one asynchronous read port.
// A read of the entry being written in the same cycle returns the old data.
module sample_ram
    import stats_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: contents are deliberately left unreset.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_window.sv
// Sliding sample window: buffers incoming samples and, every STRIDE samples
// once WIN are available, hands a [si, ei) window to a statistics engine and
// captures the engine's mean/variance result.
module sample_window
    import stats_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WIN    = 8,
    parameter int STRIDE = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              stat_start,
    output logic [DATA_W-1:0] stat_si,
    output logic [DATA_W-1:0] stat_ei,
    input  logic [DATA_W-1:0] stat_index,
    output logic [DATA_W-1:0] stat_value,
    input  logic              stat_done,
    input  logic [DATA_W-1:0] stat_mean,
    input  logic [DATA_W-1:0] stat_variance,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_si,
    output logic [DATA_W-1:0] res_mean,
    output logic [DATA_W-1:0] res_variance
);

    localparam int AW = addr_width(DEPTH);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] wr_cnt_reg, wr_cnt_inc;
    logic [DATA_W-1:0] stride_cnt_reg, stride_cnt_next;
    logic [DATA_W-1:0] stat_si_reg, stat_ei_reg;
    logic [DATA_W-1:0] res_si_reg, res_mean_reg, res_var_reg;
    logic              res_valid_reg;
    logic              accept, enter_issue, capture;
    logic [AW-1:0]     wr_addr, rd_addr;

    // Input is only open while collecting samples; the handshake is purely
    // a function of the state so there is no path from in_valid to in_ready.
    assign in_ready   = (state_reg == ST_FILL) || (state_reg == ST_RUN);
    assign accept     = in_valid && in_ready;
    assign wr_cnt_inc = wr_cnt_reg + 32'd1;

    // Buffer indices are the counters modulo DEPTH (DEPTH is a power of 2).
    assign wr_addr = AW'(wr_cnt_reg);
    assign rd_addr = AW'(stat_index);

    sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .Clk     (Clk),
        .we      (accept),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (stat_value)
    );

    // Next-state, stride bookkeeping and the start pulse.
    always_comb begin
        state_next      = state_reg;
        stride_cnt_next = stride_cnt_reg;
        enter_issue     = 1'b0;
        capture         = 1'b0;
        stat_start      = 1'b0;
        case (state_reg)
            ST_FILL: begin
                if (accept && (wr_cnt_inc == 32'(WIN))) begin
                    state_next      = ST_ISSUE;
                    stride_cnt_next = '0;
                    enter_issue     = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (stride_cnt_reg + 32'd1 == 32'(STRIDE)) begin
                        state_next      = ST_ISSUE;
                        stride_cnt_next = '0;
                        enter_issue     = 1'b1;
                    end else begin
                        stride_cnt_next = stride_cnt_reg + 32'd1;
                    end
                end
            end
            ST_ISSUE: begin
                stat_start = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // No timeout: the block stalls until the engine answers.
                if (stat_done) begin
                    capture    = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= ST_FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counters, window bounds and captured results.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_cnt_reg     <= '0;
            stride_cnt_reg <= '0;
            stat_si_reg    <= '0;
            stat_ei_reg    <= '0;
            res_valid_reg  <= 1'b0;
            res_si_reg     <= '0;
            res_mean_reg   <= '0;
            res_var_reg    <= '0;
        end else begin
            if (accept) begin
                wr_cnt_reg <= wr_cnt_inc;
            end
            stride_cnt_reg <= stride_cnt_next;
            if (enter_issue) begin
                stat_ei_reg <= wr_cnt_inc;
                stat_si_reg <= wr_cnt_inc - 32'(WIN);
            end
            res_valid_reg <= capture;
            if (capture) begin
                res_si_reg   <= stat_si_reg;
                res_mean_reg <= stat_mean;
                res_var_reg  <= stat_variance;
            end
        end
    end

    assign stat_si      = stat_si_reg;
    assign stat_ei      = stat_ei_reg;
    assign res_valid    = res_valid_reg;
    assign res_si       = res_si_reg;
    assign res_mean     = res_mean_reg;
    assign res_variance = res_var_reg;

endmodule
